// File: rtl/cacheline_mem_arbiter.sv
// cacheline_mem_arbiter
// Arbitrates icache/dcache cacheline requests onto one burst memory port.
// Each granted request becomes a BEATS-long burst of BEAT_W-bit beats; read
// beats are reassembled into a full line and returned with a one-cycle resp.
//
// Handshake: a cache raises its read/write request and holds it (and its
// address/data) until it sees its *_resp pulse. Requests are only sampled in
// IDLE. On the memory side mem_read/mem_write stay high for the whole burst,
// and every cycle with mem_resp high transfers exactly one beat.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the grant when both
// caches request together. Without it the dcache always wins a collision.
module cacheline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_line_read,
  input  logic [ADDR_W-1:0] i_line_addr,
  output logic [LINE_W-1:0] i_line_rdata,
  output logic              i_line_resp,
  input  logic              d_line_read,
  input  logic              d_line_write,
  input  logic [ADDR_W-1:0] d_line_addr,
  input  logic [LINE_W-1:0] d_line_wdata,
  output logic [LINE_W-1:0] d_line_rdata,
  output logic              d_line_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic              owner_d;      // 1 = current transaction belongs to dcache
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] line_next;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic d_req;
  logic any_req;
  logic grant_d;
  logic beat_last;

  assign d_req     = d_line_read | d_line_write;
  assign any_req   = d_req | i_line_read;
  assign beat_last = (beat_cnt == LAST_BEAT);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;  // 0 = icache got the most recent grant

  // Collision goes to whichever cache did not win the previous grant.
  always_comb begin
    grant_d = d_req;
    if (d_req && i_line_read) begin
      grant_d = ~last_grant_d;
    end
  end

  // Remember who won each grant; reset favours the dcache on the first collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_grant_d <= grant_d;
    end
  end
`else
  // Fixed priority: the dcache wins whenever it is requesting.
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Next-state logic for the burst sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = (grant_d && d_line_write) ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (mem_resp && beat_last) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read line with the current beat dropped into its slot.
  always_comb begin
    line_next = line_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt == CNT_W'(b)) begin
        line_next[b*BEAT_W +: BEAT_W] = mem_rdata;
      end
    end
  end

  // Transaction latch, beat counter, line assembly and returned-line holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      owner_d   <= 1'b0;
      addr_q    <= '0;
      wline_q   <= '0;
      line_buf  <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_d  <= grant_d;
            addr_q   <= grant_d ? (d_line_addr & ~OFF_MASK) : (i_line_addr & ~OFF_MASK);
            beat_cnt <= '0;
            line_buf <= '0;
            if (grant_d && d_line_write) begin
              wline_q <= d_line_wdata;
            end
          end
        end
        RD_BURST: begin
          if (mem_resp) begin
            line_buf <= line_next;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (beat_last) begin
              if (owner_d) begin
                d_rdata_q <= line_next;
              end else begin
                i_rdata_q <= line_next;
              end
            end
          end
        end
        WR_BURST: begin
          if (mem_resp) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side and cache-side outputs decoded from the current state.
  always_comb begin
    mem_read    = (state == RD_BURST);
    mem_write   = (state == WR_BURST);
    mem_addr    = '0;
    mem_wdata   = '0;
    i_line_resp = (state == RESP) && !owner_d;
    d_line_resp = (state == RESP) && owner_d;
    if (state == RD_BURST || state == WR_BURST) begin
      mem_addr = addr_q;
    end
    if (state == WR_BURST) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_cnt == CNT_W'(b)) begin
          mem_wdata = wline_q[b*BEAT_W +: BEAT_W];
        end
      end
    end
  end

  assign i_line_rdata = i_rdata_q;
  assign d_line_rdata = d_rdata_q;

endmodule
